// File: rtl/ds18b20_seq.sv
// ds18b20_seq: command sequencer that sits in front of the 1-Wire byte engine.
// On start it runs one DS18B20 conversion (reset, skip ROM, convert, wait,
// reset, skip ROM, read scratchpad, N_RD byte reads), checks the Dallas CRC8
// and presents the 16-bit temperature.
//
// Ports
//   clk, reset_n          system clock, synchronous active-low reset
//   start                 1-cycle measurement request, ignored unless idle
//   busy, done            run in progress / 1-cycle end-of-run pulse
//   temp, temp_valid      scratchpad {byte1, byte0}, valid after a good run
//   crc_err, no_device    status of the last run
//   ow_reset, ow_write_byte, ow_read_byte, ow_in_byte   strobes/data to one_wire
//   ow_out_byte, ow_busy, ow_presense                   results from one_wire
//
// state | meaning
// IDLE  | waiting for start
// RST1  | first bus reset + presence check
// SKIP1 | write 0xCC (skip ROM)
// CONV  | write 0x44 (convert T)
// WAIT  | conversion time, CONV_WAIT cycles
// RST2  | second bus reset + presence check
// SKIP2 | write 0xCC
// RDCMD | write 0xBE (read scratchpad)
// RDB   | read scratchpad byte idx
// CRC   | fold the captured byte into the CRC, one bit per cycle
// CHK   | compare CRC, publish temperature
// DONE  | 1-cycle success pulse
// ERR   | 1-cycle failure pulse

module ds18b20_seq #(
  parameter int unsigned CONV_WAIT = 18000000,
  parameter int unsigned N_RD      = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        crc_err,
  output logic        no_device,
  output logic        ow_reset,
  output logic        ow_write_byte,
  output logic        ow_read_byte,
  output logic [7:0]  ow_in_byte,
  input  logic [7:0]  ow_out_byte,
  input  logic        ow_busy,
  input  logic        ow_presense
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST1, S_SKIP1, S_CONV, S_WAIT, S_RST2, S_SKIP2,
    S_RDCMD, S_RDB, S_CRC, S_CHK, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {PH_ISSUE, PH_ACK, PH_FIN} phase_e;

  localparam logic [24:0] WAIT_LAST = 25'(CONV_WAIT - 1);
  localparam logic [3:0]  I_LAST    = 4'(N_RD - 1);
  localparam bit          CHECK_CRC = (N_RD == 9);

  state_e      state_q, state_d;
  phase_e      ph_q, ph_d;
  logic [1:0]  ack_q, ack_d;
  logic [24:0] wait_q, wait_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d;
  logic [15:0] temp_q, temp_d;
  logic        tv_q, tv_d, crc_err_q, crc_err_d, nodev_q, nodev_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic is_op, strobe, op_fin, do_step, go_done, go_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ph_q      <= PH_ISSUE;
      ack_q     <= '0;
      wait_q    <= '0;
      idx_q     <= '0;
      bit_q     <= '0;
      crc_q     <= '0;
      sh_q      <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      temp_q    <= '0;
      tv_q      <= 1'b0;
      crc_err_q <= 1'b0;
      nodev_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      ack_q     <= ack_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      crc_q     <= crc_d;
      sh_q      <= sh_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      temp_q    <= temp_d;
      tv_q      <= tv_d;
      crc_err_q <= crc_err_d;
      nodev_q   <= nodev_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    ack_d     = ack_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    crc_d     = crc_q;
    sh_d      = sh_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    temp_d    = temp_q;
    tv_d      = tv_q;
    crc_err_d = crc_err_q;
    nodev_d   = nodev_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    do_step   = 1'b0;
    go_done   = 1'b0;
    go_err    = 1'b0;

    is_op  = state_q inside {S_RST1, S_SKIP1, S_CONV, S_RST2, S_SKIP2, S_RDCMD, S_RDB};
    // Strobes wait for the engine to be idle, which also covers an op left
    // running in one_wire across our own reset.
    strobe = is_op && (ph_q == PH_ISSUE) && !ow_busy;
    op_fin = is_op && (ph_q == PH_FIN) && !ow_busy;

    ow_reset      = strobe && (state_q inside {S_RST1, S_RST2});
    ow_write_byte = strobe && (state_q inside {S_SKIP1, S_CONV, S_SKIP2, S_RDCMD});
    ow_read_byte  = strobe && (state_q == S_RDB);
    // Decoded from state so it stays stable for the whole op.
    case (state_q)
      S_SKIP1, S_SKIP2: ow_in_byte = 8'hCC;
      S_CONV:           ow_in_byte = 8'h44;
      S_RDCMD:          ow_in_byte = 8'hBE;
      default:          ow_in_byte = 8'h00;
    endcase

    if (is_op) begin
      case (ph_q)
        PH_ISSUE: if (!ow_busy) begin
          ph_d  = PH_ACK;
          ack_d = '0;
        end
        PH_ACK: begin
          if (ow_busy)              ph_d = PH_FIN;
          else if (ack_q == 2'd3)   ph_d = PH_ISSUE;   // strobe lost, retry
          else                      ack_d = ack_q + 2'd1;
        end
        default: if (!ow_busy) ph_d = PH_ISSUE;
      endcase
    end

    case (state_q)
      S_IDLE: if (start && !ow_busy) begin
        state_d   = S_RST1;
        busy_d    = 1'b1;
        tv_d      = 1'b0;
        crc_err_d = 1'b0;
        nodev_d   = 1'b0;
      end
      S_RST1, S_RST2: if (op_fin) begin
        if (!ow_presense) begin
          nodev_d = 1'b1;
          go_err  = 1'b1;
        end else begin
          state_d = (state_q == S_RST1) ? S_SKIP1 : S_SKIP2;
        end
      end
      S_SKIP1: if (op_fin) state_d = S_CONV;
      S_CONV: if (op_fin) begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q >= WAIT_LAST) state_d = S_RST2;
        else                     wait_d  = wait_q + 25'd1;
      end
      S_SKIP2: if (op_fin) state_d = S_RDCMD;
      S_RDCMD: if (op_fin) begin
        state_d = S_RDB;
        idx_d   = '0;
        crc_d   = '0;
      end
      S_RDB: if (op_fin) begin
        sh_d = ow_out_byte;
        if (idx_q == 4'd0) b0_d = ow_out_byte;
        if (idx_q == 4'd1) b1_d = ow_out_byte;
        if (CHECK_CRC && (idx_q <= 4'd7)) begin
          state_d = S_CRC;
          bit_d   = '0;
        end else begin
          do_step = 1'b1;
        end
      end
      S_CRC: begin
        // Reflected Dallas polynomial, LSB first; sh_q shifts out the data bits.
        crc_d = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ sh_q[0]) ? 8'h8C : 8'h00);
        sh_d  = {1'b0, sh_q[7:1]};
        if (bit_q == 3'd7) do_step = 1'b1;
        else               bit_d   = bit_q + 3'd1;
      end
      S_CHK: begin
        // sh_q still holds byte 8 here: the last byte is never shifted.
        if (CHECK_CRC && (crc_q != sh_q)) begin
          crc_err_d = 1'b1;
          go_err    = 1'b1;
        end else begin
          temp_d  = {b1_q, b0_q};
          tv_d    = 1'b1;
          go_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_step) begin
      if (idx_q == I_LAST) begin
        state_d = S_CHK;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_RDB;
      end
    end

    if (go_done || go_err) begin
      state_d = go_err ? S_ERR : S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign temp       = temp_q;
  assign temp_valid = tv_q;
  assign crc_err    = crc_err_q;
  assign no_device  = nodev_q;

endmodule

// File: tb/tb_ds18b20_seq.sv
module tb_ds18b20_seq;

  localparam int CW     = 100;
  localparam int GAP_OP = 22;   // strobe-to-next-stage time with a 20-cycle engine

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, temp_valid, crc_err, no_device;
  logic [15:0] temp;
  logic        ow_reset, ow_write_byte, ow_read_byte;
  logic [7:0]  ow_in_byte;
  logic [7:0]  ow_out_byte = 8'h00;
  logic        ow_busy;
  logic        ow_presense;

  ds18b20_seq #(.CONV_WAIT(CW), .N_RD(9)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done), .temp(temp), .temp_valid(temp_valid),
    .crc_err(crc_err), .no_device(no_device),
    .ow_reset(ow_reset), .ow_write_byte(ow_write_byte), .ow_read_byte(ow_read_byte),
    .ow_in_byte(ow_in_byte), .ow_out_byte(ow_out_byte),
    .ow_busy(ow_busy), .ow_presense(ow_presense)
  );

  always #5 clk = ~clk;

  // one_wire stub: busy for 20 cycles starting the cycle after a strobe
  logic [7:0] scratch [9];
  bit  stub_mute = 1'b0;
  bit  stub_pres = 1'b1;
  int  stub_cnt = 0;
  int  rd_ptr = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  rd_cnt = 0;
  int  viol = 0;
  logic [9:0] slog [$];   // {kind(0=R,1=W,2=RD), byte}
  int  scyc [$];

  assign ow_busy     = (stub_cnt != 0);
  assign ow_presense = stub_pres;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (ow_reset || ow_write_byte || ow_read_byte) begin
      if (ow_busy || (int'(ow_reset) + int'(ow_write_byte) + int'(ow_read_byte) > 1))
        viol <= viol + 1;
      slog.push_back({ow_read_byte ? 2'd2 : (ow_write_byte ? 2'd1 : 2'd0), ow_in_byte});
      scyc.push_back(cyc);
      if (!stub_mute) stub_cnt <= 20;
      if (ow_reset) rd_ptr <= 0;
      if (ow_read_byte) begin
        rd_cnt      <= rd_cnt + 1;
        ow_out_byte <= (rd_ptr < 9) ? scratch[rd_ptr] : 8'hFF;
        rd_ptr      <= rd_ptr + 1;
      end
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [15:0] m_temp = 16'h0000;
  bit m_tv = 1'b0, m_crc = 1'b0, m_nod = 1'b0;

  function automatic logic [7:0] ref_crc8();
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = scratch[i];
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else                       c = c >> 1;
        b = b >> 1;
      end
    end
    return c;
  endfunction

  task automatic model_run(input bit pres);
    if (!pres) begin
      m_nod = 1'b1; m_crc = 1'b0; m_tv = 1'b0;
    end else if (ref_crc8() == scratch[8]) begin
      m_temp = {scratch[1], scratch[0]}; m_tv = 1'b1; m_crc = 1'b0; m_nod = 1'b0;
    end else begin
      m_crc = 1'b1; m_tv = 1'b0; m_nod = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_temp = 16'h0000; m_tv = 1'b0; m_crc = 1'b0; m_nod = 1'b0;
  endtask

  task automatic load_vec(input logic [7:0] b8);
    scratch[0] = 8'h50; scratch[1] = 8'h05; scratch[2] = 8'h4B;
    scratch[3] = 8'h46; scratch[4] = 8'h7F; scratch[5] = 8'hFF;
    scratch[6] = 8'h0C; scratch[7] = 8'h10; scratch[8] = b8;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag);
    check_eq({tag, " temp"}, temp, m_temp);
    check_eq({tag, " temp_valid"}, temp_valid, m_tv);
    check_eq({tag, " crc_err"}, crc_err, m_crc);
    check_eq({tag, " no_device"}, no_device, m_nod);
    check_eq({tag, " busy at done"}, busy, 0);
  endtask

  function automatic int exp_kind(input int i);
    if (i == 0 || i == 3) return 0;
    if (i <= 5) return 1;
    return 2;
  endfunction

  function automatic logic [7:0] exp_byte(input int i);
    if (i == 2) return 8'h44;
    if (i == 5) return 8'hBE;
    return 8'hCC;
  endfunction

  task automatic check_strobes(input string tag, input int base, input bit pres);
    int n, got;
    logic [9:0] e;
    n   = pres ? 15 : 1;
    got = slog.size() - base;
    check_eq({tag, " strobe count"}, got, n);
    for (int i = 0; i < n && i < got; i++) begin
      e = slog[base + i];
      check_eq($sformatf("%s strobe%0d kind", tag, i), e[9:8], exp_kind(i));
      if (exp_kind(i) == 1)
        check_eq($sformatf("%s strobe%0d byte", tag, i), e[7:0], exp_byte(i));
    end
    if (pres && got >= 4) begin
      check_eq({tag, " R->CC gap"}, scyc[base + 1] - scyc[base], GAP_OP);
      check_eq({tag, " 44->R gap"}, scyc[base + 3] - scyc[base + 2], CW + GAP_OP);
    end
  endtask

  // Call at a negedge with the DUT idle and the stub not busy.
  task automatic run_full(input string tag, input bit pres);
    int base, dbase, c0;
    bit ok;
    stub_pres = pres;
    model_run(pres);
    base  = slog.size();
    dbase = done_cnt;
    start = 1'b1;
    c0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, " busy after start"}, busy, 1);
    wait_done(3000, ok);
    check_eq({tag, " done seen"}, ok, 1);
    check_result(tag);
    @(negedge clk);
    check_eq({tag, " done low after"}, done, 0);
    @(negedge clk);
    check_eq({tag, " done width"}, done_cnt - dbase, 1);
    check_strobes(tag, base, pres);
    if (slog.size() > base) check_eq({tag, " first strobe latency"}, scyc[base] - c0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " flags"},
             {busy, done, temp_valid, crc_err, no_device, ow_reset, ow_write_byte, ow_read_byte}, 0);
    check_eq({tag, " temp"}, temp, 0);
    check_eq({tag, " in_byte"}, ow_in_byte, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, c1;
    bit ok;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    load_vec(8'h1C);
    run_full("t1", 1'b1);
    check_eq("t1 temp value", temp, 16'h0550);

    load_vec(8'h1D);
    run_full("t2", 1'b1);

    load_vec(8'h1C);
    run_full("t3", 1'b0);

    // start during WAIT and during DONE ignored, accepted the cycle after DONE
    load_vec(8'h1C);
    stub_pres = 1'b1;
    model_run(1'b1);
    base  = slog.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (slog.size() - base >= 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("t4 reached conv", ok, 1);
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000, ok);
    check_eq("t4 done seen", ok, 1);
    check_result("t4");
    check_eq("t4 strobes despite start in wait", slog.size() - base, 15);
    start = 1'b1;
    @(negedge clk);
    base = slog.size();
    c1   = cyc;
    check_eq("t4 start in done ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check_eq("t4 rerun busy", busy, 1);
    check_eq("t4 rerun clears temp_valid", temp_valid, 0);
    wait_done(3000, ok);
    check_eq("t4 rerun done seen", ok, 1);
    check_result("t4 rerun");
    if (slog.size() > base) check_eq("t4 rerun first strobe", scyc[base] - c1, 1);
    else check_eq("t4 rerun any strobe", slog.size() - base, 15);
    @(negedge clk);

    for (int k = 0; k < 9; k++) scratch[k] = 8'h00;
    run_full("zero", 1'b1);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 9; k++) scratch[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) scratch[8] = ref_crc8();
      run_full($sformatf("rand%0d", r), $urandom_range(0, 7) != 0);
    end

    // reset in the middle of a read, then start while one_wire is still busy
    load_vec(8'h1C);
    stub_pres = 1'b1;
    rbase = rd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd_cnt - rbase >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("t5 reached rdb", ok, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("t5 reset");
    model_reset();
    reset_n = 1'b1;
    base  = slog.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5 start ignored while ow_busy", busy, 0);
    check_eq("t5 no strobe while ow_busy", slog.size() - base, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!ow_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("t5 engine idle", ok, 1);
    run_full("t5 recover", 1'b1);

    // engine never acknowledges: reset strobe re-issued every 5 cycles
    stub_mute = 1'b1;
    base  = slog.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("t6 reissue count", (slog.size() - base) >= 4, 1);
    for (int k = 1; k < 4; k++) begin
      if (base + k < slog.size()) begin
        check_eq($sformatf("t6 gap%0d", k), scyc[base + k] - scyc[base + k - 1], 5);
        check_eq($sformatf("t6 kind%0d", k), slog[base + k][9:8], 0);
      end
    end
    check_eq("t6 still busy", busy, 1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    stub_mute = 1'b0;
    model_reset();
    check_all_zero("t6 reset");

    check_eq("no strobe while engine busy", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
